alu_exec_unit: RTL

//   Sequential, handshaked ALU execution unit. Accepts one operation per request
//   (A, B, opcode) over a valid/ready channel, computes it (single-cycle ops, or
//   an iterative shift-add multiply) and returns a registered result over a

---
 rtl/alu_exec_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Handshaked ALU: single-cycle ops answer 1 cycle after accept, shift-add multiply after WIDTH+1.
// Accepts only in IDLE; a held response (rsp_ready low) stalls new requests with outputs frozen.
module alu_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             C_Flag,
  output logic             Cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        count;
  logic                 accept;

  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     op_out;
  logic                 op_cout;
  logic                 op_cflag;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state == MUL);
  assign accept    = req_valid & req_ready;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_comb begin
    sum      = {1'b0, A} + {1'b0, B};
    op_out   = '0;
    op_cout  = 1'b0;
    op_cflag = 1'b0;
    case (opcode)
      3'b000: begin
        op_out  = sum[WIDTH-1:0];
        op_cout = sum[WIDTH];
      end
      3'b001: begin
        op_out  = A - B;
        op_cout = (A < B);
      end
      3'b010: op_out = A & B;
      3'b011: op_out = A | B;
      3'b101: op_cflag = (A > B);
      3'b110: {op_cout, op_out} = {A, 1'b0};
      3'b111: {op_cout, op_out} = {B, 1'b0};
      default: op_out = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      ALU_OUT <= '0;
      C_Flag  <= 1'b0;
      Cout    <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (opcode == 3'b100) begin
              mcand  <= {{WIDTH{1'b0}}, A};
              mplier <= B;
              acc    <= '0;
              count  <= '0;
              state  <= MUL;
            end else begin
              ALU_OUT <= op_out;
              Cout    <= op_cout;
              C_Flag  <= op_cflag;
              state   <= RESP;
            end
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          // Last iteration: publish the product including this cycle's partial sum.
          if (count == CW'(WIDTH - 1)) begin
            ALU_OUT <= acc_nxt[WIDTH-1:0];
            Cout    <= |acc_nxt[2*WIDTH-1:WIDTH];
            C_Flag  <= 1'b0;
            state   <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
